// File: rtl/logic_gate_checker.sv
// -----------------------------------------------------------------------------
// logic_gate_checker
//
// Stimulus/response checker for a two-input, seven-output logic-gate unit.
// Steps the unit's a/b inputs through 00, 01, 10, 11. After each vector it
// waits SETTLE_CYCLES cycles, samples the seven gate outputs and compares
// them against the expected truth table. Results are sticky for the run.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for start, outputs at reset value
//   SETTLE | vector driven, waiting for the gate unit outputs to settle
//   SAMPLE | compare gate outputs against expected for current vector
//   DONE   | run finished, results held until next start or reset
//
// Parameters:
//   SETTLE_CYCLES : cycles spent in SETTLE per vector, 1..255
//
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   start      : begin a run (honoured in IDLE or DONE only)
//   a_o, b_o   : drive gate unit inputs a and b
//   and_i..xnor_i : gate unit outputs under test
//   busy       : run in progress
//   done       : run finished
//   pass       : run finished with no failing vectors
//   err_mask   : sticky per-gate mismatch {and,or,nand,nor,not,xor,xnor}
//   fail_vec   : sticky per-vector mismatch, bit v for vector v
//   err_count  : number of failing vectors, 0..4
// -----------------------------------------------------------------------------
module logic_gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    input  logic       and_i,
    input  logic       or_i,
    input  logic       nand_i,
    input  logic       nor_i,
    input  logic       not_i,
    input  logic       xor_i,
    input  logic       xnor_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_mask,
    output logic [3:0] fail_vec,
    output logic [2:0] err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] vec, vec_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       a_nxt, b_nxt;
    logic       busy_nxt, done_nxt, pass_nxt;
    logic [6:0] err_mask_nxt;
    logic [3:0] fail_vec_nxt;
    logic [2:0] err_count_nxt;

    // Expected values derive from the vector index rather than the a_o/b_o
    // registers; both always agree, but this keeps the compare self-contained.
    logic       exp_a, exp_b;
    logic [6:0] expected;
    logic [6:0] observed;
    logic [6:0] mismatch;
    logic       vec_failed;
    logic [2:0] err_count_inc;
    logic [1:0] vec_inc;

    assign exp_a    = vec[1];
    assign exp_b    = vec[0];
    assign expected = {exp_a & exp_b,
                       exp_a | exp_b,
                       ~(exp_a & exp_b),
                       ~(exp_a | exp_b),
                       ~exp_a,
                       exp_a ^ exp_b,
                       ~(exp_a ^ exp_b)};
    assign observed = {and_i, or_i, nand_i, nor_i, not_i, xor_i, xnor_i};
    assign mismatch = observed ^ expected;
    assign vec_failed = |mismatch;
    assign err_count_inc = err_count + {2'b00, vec_failed};
    assign vec_inc = vec + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= 2'd0;
            cnt       <= 8'd0;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_mask  <= 7'd0;
            fail_vec  <= 4'd0;
            err_count <= 3'd0;
        end else begin
            state     <= state_nxt;
            vec       <= vec_nxt;
            cnt       <= cnt_nxt;
            a_o       <= a_nxt;
            b_o       <= b_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err_mask  <= err_mask_nxt;
            fail_vec  <= fail_vec_nxt;
            err_count <= err_count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        vec_nxt       = vec;
        cnt_nxt       = cnt;
        a_nxt         = a_o;
        b_nxt         = b_o;
        busy_nxt      = busy;
        done_nxt      = done;
        pass_nxt      = pass;
        err_mask_nxt  = err_mask;
        fail_vec_nxt  = fail_vec;
        err_count_nxt = err_count;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt     = SETTLE;
                    vec_nxt       = 2'd0;
                    cnt_nxt       = CNT_LOAD;
                    a_nxt         = 1'b0;
                    b_nxt         = 1'b0;
                    busy_nxt      = 1'b1;
                    done_nxt      = 1'b0;
                    pass_nxt      = 1'b0;
                    err_mask_nxt  = 7'd0;
                    fail_vec_nxt  = 4'd0;
                    err_count_nxt = 3'd0;
                end
            end

            SETTLE: begin
                if (cnt == 8'd0) begin
                    state_nxt = SAMPLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end

            SAMPLE: begin
                err_mask_nxt = err_mask | mismatch;
                if (vec_failed) begin
                    fail_vec_nxt[vec] = 1'b1;
                    err_count_nxt     = err_count_inc;
                end
                if (vec == 2'd3) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    // Must include the last vector's verdict, hence the
                    // incremented count rather than the registered one.
                    pass_nxt  = (err_count_inc == 3'd0);
                end else begin
                    state_nxt = SETTLE;
                    vec_nxt   = vec_inc;
                    a_nxt     = vec_inc[1];
                    b_nxt     = vec_inc[0];
                    cnt_nxt   = CNT_LOAD;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_logic_gate_checker.sv
module tb_logic_gate_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // ---------------- DUT with SETTLE_CYCLES = 1 and a faultable gate model
    logic       start1;
    logic       a1, b1;
    logic       busy1, done1, pass1;
    logic [6:0] em1;
    logic [3:0] fv1;
    logic [2:0] ec1;
    logic       f_xor0, f_notinv, f_nand1;
    logic       and1, or1, nand1, nor1, not1, xor1, xnor1;

    assign and1  = a1 & b1;
    assign or1   = a1 | b1;
    assign nand1 = f_nand1 ? 1'b1 : ~(a1 & b1);
    assign nor1  = ~(a1 | b1);
    assign not1  = f_notinv ? a1 : ~a1;
    assign xor1  = f_xor0 ? 1'b0 : (a1 ^ b1);
    assign xnor1 = ~(a1 ^ b1);

    logic_gate_checker #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a_o(a1), .b_o(b1),
        .and_i(and1), .or_i(or1), .nand_i(nand1), .nor_i(nor1),
        .not_i(not1), .xor_i(xor1), .xnor_i(xnor1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_mask(em1), .fail_vec(fv1), .err_count(ec1)
    );

    // ---------------- DUT with SETTLE_CYCLES = 3 and a correct gate model
    logic       start3;
    logic       a3, b3;
    logic       busy3, done3, pass3;
    logic [6:0] em3;
    logic [3:0] fv3;
    logic [2:0] ec3;

    logic_gate_checker #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .a_o(a3), .b_o(b3),
        .and_i(a3 & b3), .or_i(a3 | b3), .nand_i(~(a3 & b3)),
        .nor_i(~(a3 | b3)), .not_i(~a3), .xor_i(a3 ^ b3),
        .xnor_i(~(a3 ^ b3)),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_mask(em3), .fail_vec(fv3), .err_count(ec3)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero1(input string tag);
        chk({tag, ".ab"},   {6'd0, a1, b1}, 8'd0);
        chk({tag, ".busy"}, {7'd0, busy1},  8'd0);
        chk({tag, ".done"}, {7'd0, done1},  8'd0);
        chk({tag, ".pass"}, {7'd0, pass1},  8'd0);
        chk({tag, ".em"},   {1'b0, em1},    8'd0);
        chk({tag, ".fv"},   {4'd0, fv1},    8'd0);
        chk({tag, ".ec"},   {5'd0, ec1},    8'd0);
    endtask

    // Pulse start on DUT1 and check the vector sequence edge by edge;
    // done must rise exactly 8 edges after the start edge.
    task automatic run1_timed(input string tag);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk({tag, ".start_busy"}, {7'd0, busy1}, 8'd1);
        chk({tag, ".start_done"}, {7'd0, done1}, 8'd0);
        chk({tag, ".start_pass"}, {7'd0, pass1}, 8'd0);
        chk({tag, ".start_em"},   {1'b0, em1},   8'd0);
        chk({tag, ".start_fv"},   {4'd0, fv1},   8'd0);
        chk({tag, ".start_ec"},   {5'd0, ec1},   8'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) begin
                chk($sformatf("%s.ab%0d", tag, k), {6'd0, a1, b1}, 8'(k / 2));
                chk($sformatf("%s.nodone%0d", tag, k), {7'd0, done1}, 8'd0);
            end else begin
                chk({tag, ".done"}, {7'd0, done1}, 8'd1);
                chk({tag, ".busy_end"}, {7'd0, busy1}, 8'd0);
                chk({tag, ".ab_end"}, {6'd0, a1, b1}, 8'd3);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start1   = 1'b0;
        start3   = 1'b0;
        f_xor0   = 1'b0;
        f_notinv = 1'b0;
        f_nand1  = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero1("reset1");
        chk("reset3.ab",   {6'd0, a3, b3},  8'd0);
        chk("reset3.busy", {7'd0, busy3},   8'd0);
        chk("reset3.done", {7'd0, done3},   8'd0);
        rst = 1'b0;

        // Correct model
        run1_timed("good");
        chk("good.pass", {7'd0, pass1}, 8'd1);
        chk("good.em",   {1'b0, em1},   8'd0);
        chk("good.fv",   {4'd0, fv1},   8'd0);
        chk("good.ec",   {5'd0, ec1},   8'd0);

        // xor stuck at 0: vectors 01 and 10 fail
        f_xor0 = 1'b1;
        run1_timed("xor0");
        chk("xor0.pass", {7'd0, pass1}, 8'd0);
        chk("xor0.em",   {1'b0, em1},   8'h02);
        chk("xor0.fv",   {4'd0, fv1},   8'h06);
        chk("xor0.ec",   {5'd0, ec1},   8'd2);
        repeat (3) @(negedge clk);
        chk("xor0.hold_done", {7'd0, done1}, 8'd1);
        chk("xor0.hold_ab",   {6'd0, a1, b1}, 8'd3);
        chk("xor0.hold_fv",   {4'd0, fv1},   8'h06);
        f_xor0 = 1'b0;

        // not inverted (fails every vector) and nand stuck at 1 (fails 11);
        // start from DONE clears the previous results on the start edge
        f_notinv = 1'b1;
        f_nand1  = 1'b1;
        run1_timed("multi");
        chk("multi.pass", {7'd0, pass1}, 8'd0);
        chk("multi.em",   {1'b0, em1},   8'h14);
        chk("multi.fv",   {4'd0, fv1},   8'h0F);
        chk("multi.ec",   {5'd0, ec1},   8'd4);
        f_notinv = 1'b0;
        f_nand1  = 1'b0;

        // Restart from DONE with the correct model
        run1_timed("rerun");
        chk("rerun.pass", {7'd0, pass1}, 8'd1);
        chk("rerun.ec",   {5'd0, ec1},   8'd0);

        // SETTLE_CYCLES=3: each vector held 4 cycles, start held high mid-run
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("s3.start_busy", {7'd0, busy3}, 8'd1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k < 16) begin
                chk($sformatf("s3.ab%0d", k), {6'd0, a3, b3}, 8'(k / 4));
                chk($sformatf("s3.nodone%0d", k), {7'd0, done3}, 8'd0);
            end else begin
                chk("s3.done", {7'd0, done3}, 8'd1);
            end
            start3 = (k >= 5 && k <= 9);
        end
        chk("s3.pass", {7'd0, pass3}, 8'd1);
        chk("s3.ec",   {5'd0, ec3},   8'd0);
        chk("s3.ab_end", {6'd0, a3, b3}, 8'd3);

        // Reset during vector 2's SETTLE, with a fault to leave sticky state
        f_xor0 = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid.ab_v2", {6'd0, a1, b1}, 8'd2);
        chk("mid.fv_partial", {4'd0, fv1}, 8'h02);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero1("midrst");
        f_xor0 = 1'b0;

        // rst and start together: rst wins
        rst    = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        start1 = 1'b0;
        chk_zero1("rst_start");

        run1_timed("after_rst");
        chk("after_rst.pass", {7'd0, pass1}, 8'd1);
        chk("after_rst.fv",   {4'd0, fv1},   8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net: the directed sequence above is bounded, this only guards
    // against an unexpected stall of the simulation itself.
    initial begin
        #100000;
        $display("FAIL timeout observed=stalled expected=finished");
        $fatal(1, "timeout");
    end

endmodule
